// File: rtl/nibble_sample_assembler.sv
// nibble_sample_assembler: packs nibble strobes MSB-first into samples, queues them in an FWFT FIFO
module nibble_sample_assembler #(
  parameter int NIB_WIDTH       = 4,
  parameter int NIBS_PER_SAMPLE = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NIB_WIDTH-1:0]                 nib_data,
  input  logic                                 nib_valid,
  output logic [NIB_WIDTH*NIBS_PER_SAMPLE-1:0] sample_data,
  output logic                                 sample_valid,
  input  logic                                 sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic                                 overflow,
  input  logic                                 clear_overflow,
  output logic                                 resync
);
  localparam int SW = NIB_WIDTH * NIBS_PER_SAMPLE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NIBS_PER_SAMPLE);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  logic [SW-1:0] shift_q, shift_d, word;
  logic [CW-1:0] nib_cnt_q, nib_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          resync_q, resync_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d, level;
  logic          ovf_q, ovf_d;
  logic [SW-1:0] mem [FIFO_DEPTH];
  logic          last, push, expire, empty, full, pop, wr_en, drop;
  assign word   = {shift_q[SW-NIB_WIDTH-1:0], nib_data};
  assign last   = nib_cnt_q == CW'(NIBS_PER_SAMPLE - 1);
  assign push   = nib_valid && last;
  // A nibble arriving on the expiry edge takes precedence over the timeout.
  assign expire = !nib_valid && nib_cnt_q != '0 && gap_q == GW'(TIMEOUT_CYCLES - 1);
  assign level  = wr_q - rd_q;
  assign empty  = wr_q == rd_q;
  assign full   = level == FULL_LVL;
  assign pop    = !empty && sample_ready;
  assign wr_en  = push && (!full || pop);
  assign drop   = push && full && !pop;
  always_comb begin
    shift_d   = nib_valid ? word : shift_q;
    nib_cnt_d = nib_valid ? (last ? '0 : nib_cnt_q + CW'(1)) : (expire ? '0 : nib_cnt_q);
    gap_d     = nib_valid ? '0 : (gap_q == GW'(TIMEOUT_CYCLES) ? gap_q : gap_q + GW'(1));
    resync_d  = expire;
    wr_d      = wr_q + (AW+1)'(wr_en);
    rd_d      = rd_q + (AW+1)'(pop);
    ovf_d     = drop || (ovf_q && !clear_overflow);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q   <= '0;
      nib_cnt_q <= '0;
      gap_q     <= '0;
      resync_q  <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      nib_cnt_q <= nib_cnt_d;
      gap_q     <= gap_d;
      resync_q  <= resync_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
    end
  end
  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= word;
  end
  assign sample_data  = empty ? '0 : mem[rd_q[AW-1:0]];
  assign sample_valid = !empty;
  assign fifo_level   = level;
  assign overflow     = ovf_q;
  assign resync       = resync_q;
endmodule

// File: doc/nibble_sample_assembler.md
Name: nibble_sample_assembler

Overview:
- Consumes the nibble stream produced by the Pico handshake receiver: a DATA_WIDTH-bit data bus plus a one-cycle strobe per accepted transfer.
- Packs NIBS_PER_SAMPLE consecutive nibbles, MSB-first, into one filter sample and buffers the samples in a first-word-fall-through FIFO.
- Presents the samples to the filter core on a valid/ready stream.
- A gap timeout resynchronises framing when the Pico drops a transfer mid-sample.

Parameters:
- NIB_WIDTH, 4, width of one incoming nibble (matches the receiver data width).
- NIBS_PER_SAMPLE, 4, nibbles per sample; sample width SW = NIB_WIDTH*NIBS_PER_SAMPLE (16 by default). Must be ≥2.
- FIFO_DEPTH, 8, number of sample entries; power of two, ≥2.
- TIMEOUT_CYCLES, 50000, maximum clk cycles allowed between nibbles of one sample; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- nib_data  in  NIB_WIDTH  nibble value; sampled only when nib_valid=1.
- nib_valid  in  1  one-cycle strobe, one per received nibble (the receiver's new-data pulse).
- sample_data  out  SW  FIFO head sample.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  filter core accepts the head sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of stored samples.
- overflow  out  1  sticky flag: a completed sample was dropped.
- clear_overflow  in  1  synchronous clear of overflow.
- resync  out  1  one-cycle pulse: a partial sample was discarded on timeout.

Behaviour:
- Reset (async): nib_cnt=0, shift register=0, gap counter=0, FIFO empty.
  - Outputs: sample_valid=0, sample_data=0, fifo_level=0, overflow=0, resync=0.
  - Reset mid-sample or with a full FIFO discards everything.
- Assembler:
  - nib_cnt runs 0..NIBS_PER_SAMPLE-1.
  - On nib_valid: shift <= {shift[SW-NIB_WIDTH-1:0], nib_data}; nib_cnt increments. The first nibble lands in the MSBs of the finished sample.
  - On nib_valid with nib_cnt=NIBS_PER_SAMPLE-1: the completed word {shift[SW-NIB_WIDTH-1:0], nib_data} is pushed to the FIFO on that same edge, and nib_cnt wraps to 0.
  - Latency: last nib_valid at edge N → sample_valid=1 after edge N when the FIFO was empty; sample_data is valid in that cycle.
- Gap timeout:
  - The gap counter clears on every nib_valid and otherwise increments, saturating at TIMEOUT_CYCLES.
  - When nib_cnt≠0 and the counter reaches TIMEOUT_CYCLES: nib_cnt <= 0, and resync pulses high for exactly one cycle. Shift register contents are don't-care afterwards.
  - No resync is issued while nib_cnt=0.
  - nib_valid in the cycle the timeout would fire: the nibble wins. It is accepted normally, the counter clears, and no resync is issued.
- FIFO (FWFT, registered pointers, one extra wrap bit):
  - pop = sample_valid && sample_ready.
  - push = the completion event above.
  - sample_data always shows the head entry; its value is don't-care when empty.
  - Push while full without a simultaneous pop: the word is dropped and overflow is set (sticky).
  - Push while full with a simultaneous pop: both happen and fifo_level stays at FIFO_DEPTH.
  - Push while empty: no bypass; the word becomes visible in the next cycle.
  - Push and pop together when not full/empty: fifo_level is unchanged.
  - sample_ready while empty is ignored.
  - Pointer wrap-around must preserve ordering indefinitely.
- overflow: clear_overflow=1 clears it on the next edge. A drop event in the same cycle as clear_overflow takes priority, so overflow stays 1.
- Assembly is never stalled by the FIFO; back-pressure does not reach the Pico.

Test Plan:
- Basic packing: nibbles 0xA,0xB,0xC,0xD with nib_valid strobes 5 cycles apart, sample_ready=1 → one sample 0xABCD, sample_valid high exactly 1 cycle, fifo_level returns to 0.
- Back-pressure/full: sample_ready=0, feed 9 samples 0x0001..0x0009 → fifo_level=8, overflow=1, and 0x0009 is dropped. Release ready → 0x0001..0x0008 come out in order. Pulse clear_overflow → overflow=0.
- Full with simultaneous pop: FIFO full, last nibble of 0x1234 arrives in the same cycle as a pop → no overflow, level stays 8, 0x1234 emerges last.
- Timeout: TIMEOUT_CYCLES=20. Send 0x1,0x2, then idle 25 cycles → resync pulses once at gap 20. Then 0x3,0x4,0x5,0x6 → sample 0x3456, not 0x1234.
- Timeout race: nib_valid lands in the exact expiry cycle → no resync; the sample completes normally with that nibble included.
- Reset mid-operation: assert reset after 2 nibbles with 3 samples queued → all outputs 0 immediately. After release, 0x7,0x8,0x9,0xA → 0x789A.
